// File: rtl/lane_combiner_4a1.sv
// Captures a 4-lane frame and serializes it onto one byte lane, lane 0 first.
// LANE_COMBINER_SKIP_INVALID_EN: emit only valid lanes instead of idle fill.
module lane_combiner_4a1 #(
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] IDLE_SYM = 8'hBC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in_0,
  input  logic [DATA_W-1:0] data_in_1,
  input  logic [DATA_W-1:0] data_in_2,
  input  logic [DATA_W-1:0] data_in_3,
  input  logic              valid_in_0,
  input  logic              valid_in_1,
  input  logic              valid_in_2,
  input  logic              valid_in_3,
  output logic              ready_out,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [1:0]        lane_sel,
  output logic              frame_done
);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_cnt;
  logic [1:0]        w_cnt_nxt;
  logic [DATA_W-1:0] r_data [4];
  logic [3:0]        r_valid;
  logic [3:0]        w_vin;
  logic [1:0]        w_first;
  logic [1:0]        w_next;
  logic              w_last;
  logic              w_cap;

  assign w_vin = {valid_in_3, valid_in_2, valid_in_1, valid_in_0};

`ifdef LANE_COMBINER_SKIP_INVALID_EN
  logic w_more;

  // Descending scans leave the lowest qualifying index selected.
  always_comb begin
    w_first = 2'd0;
    w_next  = r_cnt;
    w_more  = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (w_vin[i]) w_first = 2'(i);
      if (r_valid[i] && (2'(i) > r_cnt)) begin
        w_next = 2'(i);
        w_more = 1'b1;
      end
    end
  end

  assign w_last = (r_state == S_SEND) && !w_more;
`else
  assign w_first = 2'd0;
  assign w_next  = r_cnt + 2'd1;
  assign w_last  = (r_state == S_SEND) && (r_cnt == 2'd3);
`endif

  assign ready_out = (r_state == S_IDLE) || w_last;
  assign w_cap     = ready_out && (|w_vin);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 4'd0;
      for (int i = 0; i < 4; i++) r_data[i] <= '0;
    end else if (w_cap) begin
      r_valid   <= w_vin;
      r_data[0] <= data_in_0;
      r_data[1] <= data_in_1;
      r_data[2] <= data_in_2;
      r_data[3] <= data_in_3;
    end
  end

  // cnt only returns to 0 through reload or idle, never by 2-bit wrap.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_cap) begin
      w_state_nxt = S_SEND;
      w_cnt_nxt   = w_first;
    end else if (r_state == S_SEND) begin
      if (w_last) begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 2'd0;
      end else begin
        w_cnt_nxt = w_next;
      end
    end
  end

  always_comb begin
    data_out   = IDLE_SYM;
    valid_out  = 1'b0;
    lane_sel   = 2'd0;
    frame_done = 1'b0;
    if (r_state == S_SEND) begin
      lane_sel   = r_cnt;
      valid_out  = r_valid[r_cnt];
      frame_done = w_last;
      if (r_valid[r_cnt]) data_out = r_data[r_cnt];
    end
  end

endmodule
